const_bank: RTL and testbench

- Parametrised successor to the fixed GF(3^M) constant ROM.
- Supplies the datapath's constant operand on a one-hot address with a one-cycle registered read and an `effective` flag.
- Adds NUM_USER run-time programmable constant slots, loaded serially one GF(3) coefficient per beat by a small FSM.
- Sits beside the register file and feeds the same operand mux as the old constant block.

---
 rtl/const_bank_pkg.sv | 27 ++
 rtl/const_loader.sv | 101 ++++++++++
 rtl/const_bank.sv | 93 +++++++++
 tb/tb_const_bank.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/const_bank_pkg.sv
// Shared definitions for the GF(3^M) constant bank: field size, trit codes,
// fixed high-coefficient constant patterns and the loader state encoding.
// No logic; imported by const_loader and const_bank.
package const_bank_pkg;

    // Degree of the irreducible polynomial and element width (2 bits per coefficient).
    localparam int CB_M  = 593;
    localparam int CB_DW = 2 * (CB_M + 1);

    // GF(3) coefficient encodings carried on ld_trit.
    localparam logic [1:0] TRIT_0   = 2'b00;
    localparam logic [1:0] TRIT_1   = 2'b01;
    localparam logic [1:0] TRIT_2   = 2'b10;
    localparam logic [1:0] TRIT_ILL = 2'b11;

    // Top three coefficients of the fixed constants; all lower coefficients are zero.
    localparam logic [5:0] PAT_A = 6'b000101;
    localparam logic [5:0] PAT_B = 6'b001001;
    localparam logic [5:0] PAT_C = 6'b010101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } ld_state_t;

endpackage

// File: rtl/const_loader.sv
// Serial loader for user constant slots: one GF(3) coefficient per ld_valid beat into a shadow register.
// Latency: wr_en pulses in the cycle after the final beat (COMMIT); ld_err appears the cycle after the offending input.
// Backpressure: none; ld_valid beats are taken whenever in LOAD, ld_start is dropped while busy.
//
// Ports: clk, reset_n; ld_start/ld_slot (begin a load), ld_valid/ld_trit (coefficient beats),
//        ld_busy/ld_err (status), wr_en/wr_slot/wr_data (slot write port toward const_bank).
module const_loader
    import const_bank_pkg::*;
#(
    parameter int DW       = CB_DW,
    parameter int NUM_USER = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ld_start,
    input  logic [2:0]    ld_slot,
    input  logic          ld_valid,
    input  logic [1:0]    ld_trit,
    output logic          ld_busy,
    output logic          ld_err,
    output logic          wr_en,
    output logic [2:0]    wr_slot,
    output logic [DW-1:0] wr_data
);

    localparam int NC = DW / 2;
    localparam int CW = $clog2(NC);
    localparam logic [CW-1:0] LAST = CW'(NC - 1);

    ld_state_t      state;
    logic [CW-1:0]  cnt;
    logic [DW-1:0]  shadow;
    logic [2:0]     slot_q;
    logic [CW:0]    bit_idx;
    logic           slot_ok;

    // Coefficient c lives in bits [2c+1:2c].
    assign bit_idx = {cnt, 1'b0};
    assign slot_ok = ({29'b0, ld_slot} < NUM_USER);

    assign wr_slot = slot_q;
    assign wr_data = shadow;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            shadow  <= '0;
            slot_q  <= '0;
            ld_busy <= 1'b0;
            ld_err  <= 1'b0;
            wr_en   <= 1'b0;
        end else begin
            ld_err <= 1'b0;
            wr_en  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ld_start) begin
                        if (slot_ok) begin
                            slot_q  <= ld_slot;
                            shadow  <= '0;
                            cnt     <= '0;
                            state   <= ST_LOAD;
                            ld_busy <= 1'b1;
                        end else begin
                            ld_err <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (ld_valid) begin
                        if (ld_trit == TRIT_ILL) begin
                            // Abort: shadow is discarded, the slot is never written.
                            state   <= ST_IDLE;
                            ld_busy <= 1'b0;
                            ld_err  <= 1'b1;
                        end else begin
                            shadow[bit_idx +: 2] <= ld_trit;
                            if (cnt == LAST) begin
                                // Counter is left at LAST; it is cleared on the next accepted start.
                                state <= ST_COMMIT;
                                wr_en <= 1'b1;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                end
                ST_COMMIT: begin
                    state   <= ST_IDLE;
                    ld_busy <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    ld_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/const_bank.sv
// GF(3^M) constant operand source: five fixed constants plus NUM_USER serially loadable slots.
// Latency: one cycle from addr to out/effective; a committed slot is visible to reads issued after the COMMIT cycle.
// Backpressure: none; reads are taken every cycle, loads are throttled only by ld_busy.
//
// Ports: clk, reset_n; addr (one-hot select) -> out, effective (registered);
//        ld_start/ld_slot/ld_valid/ld_trit -> ld_busy/ld_err (slot loader).
module const_bank
    import const_bank_pkg::*;
#(
    parameter int M        = CB_M,
    parameter int DW       = 2 * (M + 1),
    parameter int NUM_USER = 4,
    parameter int ADDR_W   = 5 + NUM_USER
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr,
    output logic [DW-1:0]     out,
    output logic              effective,
    input  logic              ld_start,
    input  logic [2:0]        ld_slot,
    input  logic              ld_valid,
    input  logic [1:0]        ld_trit,
    output logic              ld_busy,
    output logic              ld_err
);

    logic          wr_en;
    logic [2:0]    wr_slot;
    logic [DW-1:0] wr_data;

    logic [DW-1:0] slot_q [NUM_USER];
    logic [DW-1:0] rd_val;
    logic          rd_eff;

    const_loader #(
        .DW       (DW),
        .NUM_USER (NUM_USER)
    ) u_loader (
        .clk      (clk),
        .reset_n  (reset_n),
        .ld_start (ld_start),
        .ld_slot  (ld_slot),
        .ld_valid (ld_valid),
        .ld_trit  (ld_trit),
        .ld_busy  (ld_busy),
        .ld_err   (ld_err),
        .wr_en    (wr_en),
        .wr_slot  (wr_slot),
        .wr_data  (wr_data)
    );

    // Read mux: anything other than exactly one hot bit yields zero and effective=0.
    always_comb begin
        rd_val = '0;
        rd_eff = $onehot(addr);
        if (rd_eff) begin
            if (addr[1]) rd_val[1:0]       = 2'b01;
            if (addr[2]) rd_val[DW-1 -: 6] = PAT_A;
            if (addr[3]) rd_val[DW-1 -: 6] = PAT_B;
            if (addr[4]) rd_val[DW-1 -: 6] = PAT_C;
            for (int k = 0; k < NUM_USER; k++) begin
                if (addr[5+k]) rd_val = slot_q[k];
            end
            // Address bits beyond the implemented slots select nothing.
            for (int i = 5 + NUM_USER; i < ADDR_W; i++) begin
                if (addr[i]) rd_eff = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out       <= '0;
            effective <= 1'b0;
        end else begin
            out       <= rd_val;
            effective <= rd_eff;
        end
    end

    // Slot write and read share an edge, so a read in the COMMIT cycle sees the old value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_USER; k++) slot_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_USER; k++) begin
                if (wr_en && (wr_slot == 3'(k))) slot_q[k] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_const_bank.sv
module tb_const_bank;

    localparam int DW = 1188;
    localparam int NC = DW / 2;
    localparam int NU = 4;
    localparam int AW = 5 + NU;

    logic          clk;
    logic          reset_n;
    logic [AW-1:0] addr;
    logic [DW-1:0] out;
    logic          effective;
    logic          ld_start;
    logic [2:0]    ld_slot;
    logic          ld_valid;
    logic [1:0]    ld_trit;
    logic          ld_busy;
    logic          ld_err;

    int n_cmp;
    int n_bad;

    logic [DW-1:0] model_slot [NU];
    logic [1:0]    trits [NC];

    const_bank #(.NUM_USER(NU)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .addr      (addr),
        .out       (out),
        .effective (effective),
        .ld_start  (ld_start),
        .ld_slot   (ld_slot),
        .ld_valid  (ld_valid),
        .ld_trit   (ld_trit),
        .ld_busy   (ld_busy),
        .ld_err    (ld_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Expected {effective, out} for an address, from the read rules and the slot model.
    function automatic logic [DW:0] ref_read(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        logic [5:0]    hi [3];
        int            idx;
        hi[0] = 6'b000101;
        hi[1] = 6'b001001;
        hi[2] = 6'b010101;
        v   = '0;
        idx = -1;
        if ($countones(a) != 1) return '0;
        for (int i = 0; i < AW; i++) if (a[i]) idx = i;
        if (idx == 1)                      v = DW'(1);
        else if (idx >= 2 && idx <= 4)     v[DW-1 -: 6] = hi[idx-2];
        else if (idx >= 5)                 v = model_slot[idx-5];
        return {1'b1, v};
    endfunction

    function automatic logic [DW-1:0] build_word();
        logic [DW-1:0] w;
        w = '0;
        for (int c = 0; c < NC; c++) w[2*c +: 2] = trits[c];
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_read(input logic [AW-1:0] a, input string tag);
        logic [DW:0] e;
        addr = a;
        e = ref_read(a);
        step();
        n_cmp++;
        if (out !== e[DW-1:0]) begin
            n_bad++;
            $display("FAIL %s out addr=%b: got[63:0]=%h want[63:0]=%h bits_differing=%0d",
                     tag, a, out[63:0], e[63:0], $countones(out ^ e[DW-1:0]));
        end
        n_cmp++;
        if (effective !== e[DW]) begin
            n_bad++;
            $display("FAIL %s effective addr=%b: got %b want %b", tag, a, effective, e[DW]);
        end
    endtask

    task automatic check_status(input logic busy_exp, input logic err_exp, input string tag);
        n_cmp++;
        if (ld_busy !== busy_exp) begin
            n_bad++;
            $display("FAIL %s ld_busy: got %b want %b", tag, ld_busy, busy_exp);
        end
        n_cmp++;
        if (ld_err !== err_exp) begin
            n_bad++;
            $display("FAIL %s ld_err: got %b want %b", tag, ld_err, err_exp);
        end
    endtask

    task automatic fill_mod3();
        for (int c = 0; c < NC; c++) trits[c] = 2'(c % 3);
    endtask

    task automatic fill_random();
        for (int c = 0; c < NC; c++) trits[c] = 2'($urandom_range(0, 2));
    endtask

    // Full load of trits[] into slot; abort_at / reset_at = beat number or -1.
    // Stray ld_start pulses are thrown in while busy; they must be ignored.
    task automatic do_load(input int slot, input int abort_at, input int reset_at);
        ld_slot  = 3'(slot);
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        check_status(1'b1, 1'b0, "load_accept");
        for (int c = 0; c < NC; c++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                ld_valid = 1'b0;
                ld_trit  = 2'($urandom);
                ld_start = 1'($urandom);
                ld_slot  = 3'($urandom);
                step();
                check_status(1'b1, 1'b0, "load_gap");
            end
            ld_start = 1'b0;
            if (c == reset_at) begin
                reset_n = 1'b0;
                #1;
                n_cmp++;
                if (out !== '0) begin
                    n_bad++;
                    $display("FAIL reset_mid out: got[63:0]=%h want 0", out[63:0]);
                end
                n_cmp++;
                if (effective !== 1'b0) begin
                    n_bad++;
                    $display("FAIL reset_mid effective: got %b want 0", effective);
                end
                check_status(1'b0, 1'b0, "reset_mid");
                for (int k = 0; k < NU; k++) model_slot[k] = '0;
                ld_valid = 1'b0;
                step();
                reset_n = 1'b1;
                return;
            end
            ld_valid = 1'b1;
            ld_trit  = (c == abort_at) ? 2'b11 : trits[c];
            step();
            if (c == abort_at) begin
                ld_valid = 1'b0;
                check_status(1'b0, 1'b1, "abort_pulse");
                step();
                check_status(1'b0, 1'b0, "abort_after");
                return;
            end
        end
        // Now in the COMMIT cycle; a beat here must be ignored.
        ld_valid = 1'b1;
        ld_trit  = 2'($urandom_range(0, 2));
        check_status(1'b1, 1'b0, "commit_busy");
        check_read(AW'(1) << (5 + slot), "read_in_commit_old");
        ld_valid = 1'b0;
        check_status(1'b0, 1'b0, "after_commit");
        model_slot[slot] = build_word();
        check_read(AW'(1) << (5 + slot), "read_after_commit_new");
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        n_cmp++;
        if (out !== '0) begin
            n_bad++;
            $display("FAIL reset out: got[63:0]=%h want 0", out[63:0]);
        end
        n_cmp++;
        if (effective !== 1'b0) begin
            n_bad++;
            $display("FAIL reset effective: got %b want 0", effective);
        end
        check_status(1'b0, 1'b0, "reset");
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_fixed_reads();
        for (int i = 0; i < 5; i++) check_read(AW'(1) << i, "fixed");
        for (int n = 0; n < 20; n++) check_read(AW'(1) << $urandom_range(0, AW-1), "onehot_rand");
    endtask

    task automatic test_invalid_reads();
        logic [AW-1:0] a;
        check_read('0, "addr_zero");
        check_read(AW'(3), "addr_multi");
        check_read(AW'(1 << (5 + NU)), "addr_beyond");
        for (int n = 0; n < 10; n++) begin
            do a = AW'($urandom); while ($countones(a) < 2);
            check_read(a, "multi_rand");
        end
    endtask

    task automatic test_load_pattern();
        fill_mod3();
        do_load(2, -1, -1);
    endtask

    task automatic test_reload_commit_read();
        fill_random();
        do_load(2, -1, -1);
        fill_random();
        do_load(0, -1, -1);
        for (int k = 0; k < AW; k++) check_read(AW'(1) << k, "all_after_loads");
    endtask

    task automatic test_abort();
        fill_random();
        do_load(2, 100, -1);
        check_read(AW'(1) << 7, "slot_kept_after_abort");
    endtask

    task automatic test_bad_slot();
        for (int s = 4; s < 8; s++) begin
            ld_slot  = 3'(s);
            ld_start = 1'b1;
            step();
            ld_start = 1'b0;
            check_status(1'b0, 1'b1, "bad_slot_pulse");
            step();
            check_status(1'b0, 1'b0, "bad_slot_after");
        end
    endtask

    task automatic test_idle_valid_ignored();
        for (int n = 0; n < 6; n++) begin
            ld_valid = 1'b1;
            ld_trit  = 2'($urandom);
            step();
            check_status(1'b0, 1'b0, "idle_valid");
        end
        ld_valid = 1'b0;
        for (int k = 0; k < NU; k++) check_read(AW'(1) << (5 + k), "idle_valid_slots");
    endtask

    task automatic test_reset_mid_load();
        check_read(AW'(1) << 7, "pre_reset_read");
        fill_random();
        do_load(1, -1, 300);
        for (int k = 0; k < NU; k++) check_read(AW'(1) << (5 + k), "slots_after_reset");
        fill_mod3();
        do_load(1, -1, -1);
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        reset_n  = 1'b0;
        addr     = '0;
        ld_start = 1'b0;
        ld_slot  = '0;
        ld_valid = 1'b0;
        ld_trit  = '0;
        for (int k = 0; k < NU; k++) model_slot[k] = '0;

        test_reset();
        test_fixed_reads();
        test_invalid_reads();
        test_load_pattern();
        test_reload_commit_read();
        test_abort();
        test_bad_slot();
        test_idle_valid_ignored();
        test_reset_mid_load();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
